mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing one unified 16-bit data memory between the fetch stage (I-side) and the memory stage (D-side) of the pipelined processor. Each requester holds a level request until a one-cycle done pulse. The arbiter sequences a fixed-latency memory transaction through an issue/wait/response FSM and stalls the losing stage. Illegal requests are flagged on a sticky err that feeds the processor's err output.

## Interface
- AW, 16, address width
- DW, 16, data width
- LAT, 4, memory read latency in cycles (LAT >= 1)
- STARVE_LIMIT, 4, consecutive D-side wins tolerated before I-side is forced (used only with fairness enabled)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- i_rd  in  1  I-side read request (I-side never writes)
- i_addr  in  AW  I-side address
- i_rdata  out  DW  I-side read data, valid while i_done
- i_done  out  1  I-side completion pulse
- i_stall  out  1  i_rd & ~i_done
- d_rd, d_wr  in  1  D-side read / write request
- d_addr  in  AW  D-side address
- d_wdata  in  DW  D-side write data
- d_rdata  out  DW  D-side read data, valid while d_done
- d_done  out  1  D-side completion pulse
- d_stall  out  1  (d_rd|d_wr) & ~d_done
- mem_en  out  1  memory issue strobe, one cycle per transaction
- mem_wr  out  1  write qualifier for mem_en
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle
- owner  out  1  1 = D-side holds the current grant; 0 = I-side or idle
- err  out  1  sticky illegal-request flag

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is present, pick a winner, latch addr, wdata, wr and owner, then go to ISSUE. Stay in IDLE if there is no request.
- Priority: D-side wins when both sides request.
- Illegal winner: d_rd&d_wr, or addr[0]=1. Set err, go directly to RESP, no mem_en, rdata=0.
- ISSUE: mem_en=1 for exactly one cycle. Load cnt=LAT-1. Go to WAIT.
- WAIT: lasts exactly LAT cycles. cnt decrements each cycle. On cnt==0, capture mem_rdata (reads only) and go to RESP.
- RESP: winner's done=1 and rdata=captured value; rdata=0 for writes. Go to IDLE. Requests are not sampled in RESP.
- Requesters drop or change their request in the cycle after done. A request still held is treated as new in the next IDLE cycle.
- Requests arriving in ISSUE, WAIT or RESP wait; the stall outputs remain asserted.
- mem_addr and mem_wdata hold their latched values from ISSUE through RESP. mem_wr is 0 outside ISSUE.

## Timing
- Request first sampled in IDLE at cycle 0: ISSUE at cycle 1, WAIT at cycles 2..LAT+1, done at cycle LAT+2.
- Throughput is one transaction per LAT+3 cycles.
- Illegal request: done at cycle 1.
- Reset values: all outputs 0, state IDLE, err 0, starve counter 0.
- Reset asserted mid-transaction returns the FSM to IDLE immediately, with no done pulse. The in-flight memory operation is abandoned.
- err clears only on rst.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 3-bit starve counter increments on each D-side grant made while i_rd is pending, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, the next tie goes to I-side.
  - The counter clears on any I-side grant.
- MEM_ARB_FAIR_EN undefined: strict D-side priority; no counter is instantiated.

## Structure
- Shared package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - owner constants OWN_I=1'b0, OWN_D=1'b1
  - default LAT
- Sub-module mem_arb_sel: combinational winner and illegal detection, plus the starve counter under MEM_ARB_FAIR_EN.
- The top module holds the FSM, latches and cnt.

## Test plan
- LAT=4, d_rd with d_addr=16'h0010, memory holds 16'hBEEF → mem_en at cycle 1, d_done at cycle 6 with d_rdata=16'hBEEF, owner=1.
- Simultaneous i_rd at 16'h0000 and d_wr at 16'h0020 with wdata 16'h1234 → D served first (mem_wr=1, d_done at cycle 6, i_stall high throughout); I served next, i_done at cycle 13.
- d_rd=d_wr=1 → err=1 and d_done at cycle 1, no mem_en; err stays 1 through later legal transactions.
- i_addr=16'h0003 → err=1, i_done at cycle 1, i_rdata=0.
- MEM_ARB_FAIR_EN with STARVE_LIMIT=4, both sides requesting continuously → grant sequence D,D,D,D,I,D,D,D,D,I; undefined → D only.
- rst pulsed during WAIT → all outputs 0 immediately, no done; a request held after reset completes normally from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified I/D memory arbiter: FSM encoding,
// grant-owner constants and default timing parameters.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int unsigned DEFAULT_LAT          = 4;
   localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection and illegal-request detection for mem_arbiter.
// With MEM_ARB_FAIR_EN defined, a saturating starve counter lets I-side win a tie.
module mem_arb_sel
   import mem_arb_pkg::*;
`ifdef MEM_ARB_FAIR_EN
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
)
`endif
(
`ifdef MEM_ARB_FAIR_EN
   input  logic clk,
   input  logic rst,
   input  logic grant,
`endif
   input  logic i_rd,
   input  logic d_rd,
   input  logic d_wr,
   input  logic i_addr_lsb,
   input  logic d_addr_lsb,
   output logic req_any,
   output logic win_d,
   output logic illegal
);

   logic d_req;
   logic force_i;

`ifdef MEM_ARB_FAIR_EN
   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0] starve_q, starve_d;

   assign force_i = i_rd & (starve_q == LIMIT);

   // Only D wins made while I is waiting count towards starvation.
   always_comb begin
      starve_d = starve_q;
      if (grant && req_any) begin
         if (!win_d) begin
            starve_d = '0;
         end else if (i_rd && (starve_q != LIMIT)) begin
            starve_d = starve_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_i = 1'b0;
`endif

   always_comb begin
      d_req   = d_rd | d_wr;
      req_any = i_rd | d_req;
      win_d   = d_req & ~force_i;
      illegal = win_d ? ((d_rd & d_wr) | d_addr_lsb) : (i_rd & i_addr_lsb);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and memory (D) stages with an
// IDLE/ISSUE/WAIT/RESP FSM. Optional fairness via MEM_ARB_FAIR_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW           = 16,
   parameter int unsigned DW           = 16,
   parameter int unsigned LAT          = DEFAULT_LAT,
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_rd,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_done,
   output logic          i_stall,
   input  logic          d_rd,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   output logic          d_stall,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner,
   output logic          err
);

   localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

   arb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          wr_q, wr_d;
   logic          own_q, own_d;
   logic          err_q, err_d;
   logic          req_any, win_d, illegal;
   logic          resp;

`ifdef MEM_ARB_FAIR_EN
   mem_arb_sel #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_sel (
      .clk       (clk),
      .rst       (rst),
      .grant     (state_q == IDLE),
      .i_rd      (i_rd),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .i_addr_lsb(i_addr[0]),
      .d_addr_lsb(d_addr[0]),
      .req_any   (req_any),
      .win_d     (win_d),
      .illegal   (illegal)
   );
`else
   mem_arb_sel u_sel (
      .i_rd      (i_rd),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .i_addr_lsb(i_addr[0]),
      .d_addr_lsb(d_addr[0]),
      .req_any   (req_any),
      .win_d     (win_d),
      .illegal   (illegal)
   );
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wr_d    = wr_q;
      own_d   = own_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               own_d   = win_d ? OWN_D : OWN_I;
               addr_d  = win_d ? d_addr : i_addr;
               wr_d    = win_d & d_wr;
               wdata_d = win_d ? d_wdata : wdata_q;
               rdata_d = '0;
               // Illegal winners skip the memory entirely and answer with zero data.
               if (illegal) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = CW'(LAT - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               if (!wr_q) begin
                  rdata_d = mem_rdata;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wr_q    <= 1'b0;
         own_q   <= OWN_I;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wr_q    <= wr_d;
         own_q   <= own_d;
         err_q   <= err_d;
      end
   end

   assign resp      = (state_q == RESP);
   assign i_done    = resp & (own_q == OWN_I);
   assign d_done    = resp & (own_q == OWN_D);
   assign i_rdata   = i_done ? rdata_q : '0;
   assign d_rdata   = d_done ? rdata_q : '0;
   assign i_stall   = i_rd & ~i_done;
   assign d_stall   = (d_rd | d_wr) & ~d_done;
   assign mem_en    = (state_q == ISSUE);
   assign mem_wr    = (state_q == ISSUE) & wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign owner     = (state_q != IDLE) & own_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, self-checking bench for mem_arbiter with LAT=4 and STARVE_LIMIT=4.
// Honours MEM_ARB_FAIR_EN for the expected grant order under contention.
module tb_mem_arbiter;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rd, d_rd, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, owner, err;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(
      .AW(16), .DW(16), .LAT(LAT), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner), .err(err)
   );

   always #5 clk = ~clk;

   // Memory model: fixed contents plus written words; read data appears LAT cycles after mem_en.
   logic [15:0] wmem   [0:255];
   logic        wvalid [0:255];
   logic [15:0] pipe   [0:LAT-1];

   function automatic logic [15:0] init_val(input logic [7:0] idx);
      return (idx == 8'd8) ? 16'hBEEF : (16'hA000 + {8'h00, idx});
   endfunction

   function automatic logic [15:0] mem_read(input logic [7:0] idx);
      return wvalid[idx] ? wmem[idx] : init_val(idx);
   endfunction

   assign mem_rdata = pipe[LAT-1];

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 256; k++) wvalid[k] <= 1'b0;
      end else if (mem_en && mem_wr) begin
         wmem[mem_addr[8:1]]   <= mem_wdata;
         wvalid[mem_addr[8:1]] <= 1'b1;
      end
      pipe[0] <= (mem_en && !mem_wr) ? mem_read(mem_addr[8:1]) : 16'hDEAD;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        i_rd, d_rd, d_wr;
      logic [15:0] i_addr, d_addr, d_wdata;
      logic        exp_d;
      int          exp_cyc;
      logic [15:0] exp_rdata;
      int          exp_en;
      logic        exp_wr;
      logic [15:0] exp_maddr;
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];

   task automatic idle_inputs();
      i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
   endtask

   task automatic run_vec(input vec_t v);
      int          done_cyc = -1;
      int          en_cnt   = 0;
      logic        wr_seen  = 1'b0;
      logic        other    = 1'b0;
      logic        stall_ok = 1'b1;
      logic [15:0] maddr    = '0;
      logic [15:0] rdata    = '0;
      logic        own      = 1'b0;
      logic        mydone, mystall;
      @(posedge clk); #1;
      i_rd = v.i_rd; d_rd = v.d_rd; d_wr = v.d_wr;
      i_addr = v.i_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
      for (int c = 0; c < 20 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (mem_en) begin en_cnt++; maddr = mem_addr; end
         if (mem_wr) wr_seen = 1'b1;
         mydone  = v.exp_d ? d_done : i_done;
         mystall = v.exp_d ? d_stall : i_stall;
         if (v.exp_d ? i_done : d_done) other = 1'b1;
         if (mydone) begin
            done_cyc = c;
            rdata    = v.exp_d ? d_rdata : i_rdata;
            own      = owner;
            if (mystall) stall_ok = 1'b0;
         end else if (!mystall) begin
            stall_ok = 1'b0;
         end
         @(posedge clk);
      end
      #1; idle_inputs();
      check({v.name, "_done_cycle"}, done_cyc, v.exp_cyc);
      check({v.name, "_rdata"}, rdata, v.exp_rdata);
      check({v.name, "_owner"}, own, v.exp_d);
      check({v.name, "_mem_en_count"}, en_cnt, v.exp_en);
      check({v.name, "_mem_wr"}, wr_seen, v.exp_wr);
      if (v.exp_en > 0) check({v.name, "_mem_addr"}, maddr, v.exp_maddr);
      check({v.name, "_err"}, err, v.exp_err);
      check({v.name, "_other_done"}, other, 1'b0);
      check({v.name, "_stall"}, stall_ok, 1'b1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
   endtask

   initial begin
      int          d_cyc, i_cyc, g;
      logic        stall_ok, wr_in_d, own_d, saw_done;
      logic [15:0] i_val, d_val;
      logic [9:0]  exp_seq, got_seq;

      vecs[0] = '{"d_read",     1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b1, 6, 16'hBEEF, 1, 1'b0, 16'h0010, 1'b0};
      vecs[1] = '{"i_read",     1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, 6, 16'hA002, 1, 1'b0, 16'h0004, 1'b0};
      vecs[2] = '{"d_write",    1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h1234, 1'b1, 6, 16'h0000, 1, 1'b1, 16'h0020, 1'b0};
      vecs[3] = '{"d_readback", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h0000, 1'b1, 6, 16'h1234, 1, 1'b0, 16'h0020, 1'b0};
      vecs[4] = '{"i_odd_addr", 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1, 16'h0000, 0, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{"d_rd_and_wr",1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, 16'h5555, 1'b1, 1, 16'h0000, 0, 1'b0, 16'h0000, 1'b1};
      vecs[6] = '{"d_odd_addr", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0011, 16'h0000, 1'b1, 1, 16'h0000, 0, 1'b0, 16'h0000, 1'b1};
      vecs[7] = '{"d_read_sticky", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b1, 6, 16'hBEEF, 1, 1'b0, 16'h0010, 1'b1};

      idle_inputs();
      rst = 1'b1;
      #1;
      check("reset_outputs",
            {i_rdata, d_rdata, mem_addr, mem_wdata, i_done, i_stall, d_done, d_stall, mem_en, mem_wr, owner, err},
            '0);
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      @(negedge clk);
      check("post_reset_idle", {mem_en, i_done, d_done, owner, err}, '0);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Contention: D write wins first, I read follows once D drops its request.
      @(posedge clk); #1;
      i_rd = 1'b1; i_addr = 16'h0000; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
      d_cyc = -1; i_cyc = -1; stall_ok = 1'b1; wr_in_d = 1'b0; own_d = 1'b0; i_val = '0;
      for (int c = 0; c < 40 && i_cyc < 0; c++) begin
         @(negedge clk);
         if (mem_wr && d_cyc < 0) wr_in_d = 1'b1;
         if (d_done) begin d_cyc = c; own_d = owner; end
         if (i_done) begin i_cyc = c; i_val = i_rdata; end
         else if (!i_stall) stall_ok = 1'b0;
         @(posedge clk); #1;
         if (d_cyc >= 0) d_wr = 1'b0;
      end
      idle_inputs();
      check("tie_d_done_cycle", d_cyc, 6);
      check("tie_d_owner", own_d, 1'b1);
      check("tie_d_mem_wr", wr_in_d, 1'b1);
      check("tie_i_done_cycle", i_cyc, 13);
      check("tie_i_rdata", i_val, 16'hA000);
      check("tie_i_stall", stall_ok, 1'b1);

      for (int i = 4; i < 8; i++) run_vec(vecs[i]);

      // Reset during WAIT abandons the transaction; the held request then restarts.
      @(posedge clk); #1;
      d_rd = 1'b1; d_addr = 16'h0010;
      repeat (3) @(posedge clk);
      #2; rst = 1'b1;
      #1;
      check("midreset_outputs",
            {i_rdata, d_rdata, mem_addr, mem_wdata, i_done, d_done, mem_en, mem_wr, owner, err},
            '0);
      @(negedge clk);
      saw_done = d_done | i_done;
      @(posedge clk); #1;
      rst = 1'b0;
      d_cyc = -1; d_val = '0;
      for (int c = 0; c < 20 && d_cyc < 0; c++) begin
         @(negedge clk);
         if (d_done) begin d_cyc = c; d_val = d_rdata; end
         @(posedge clk);
      end
      #1; idle_inputs();
      check("midreset_no_done", saw_done, 1'b0);
      check("midreset_restart_cycle", d_cyc, 6);
      check("midreset_restart_rdata", d_val, 16'hBEEF);
      check("midreset_err_cleared", err, 1'b0);

      // Both sides request continuously; record which side each completion belongs to.
      do_reset();
`ifdef MEM_ARB_FAIR_EN
      exp_seq = 10'b0111101111;
`else
      exp_seq = 10'b1111111111;
`endif
      got_seq = '0;
      g = 0;
      @(posedge clk); #1;
      i_rd = 1'b1; i_addr = 16'h0000; d_rd = 1'b1; d_addr = 16'h0010;
      for (int c = 0; c < 200 && g < 10; c++) begin
         @(negedge clk);
         if (d_done || i_done) begin
            got_seq[g] = d_done;
            g++;
         end
         @(posedge clk);
      end
      #1; idle_inputs();
      check("fair_grant_count", g, 10);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("fair_grant_%0d", k), got_seq[k], exp_seq[k]);
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
